// File: rtl/butterfly_r2_pipe.sv
// Radix-2 complex butterfly for the FFT datapath: DIT or DIF selected per sample, 4-cycle latency,
// optional /2 scaling with round-half-up, saturating outputs and a sticky overflow flag.
module butterfly_r2_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic          mode,
    input  logic          scale,
    input  logic [DW-1:0] xp_re,
    input  logic [DW-1:0] xp_im,
    input  logic [DW-1:0] xq_re,
    input  logic [DW-1:0] xq_im,
    input  logic [TW-1:0] factor_re,
    input  logic [TW-1:0] factor_im,
    input  logic          ovf_clr,
    output logic          out_vld,
    output logic [DW-1:0] yp_re,
    output logic [DW-1:0] yp_im,
    output logic [DW-1:0] yq_re,
    output logic [DW-1:0] yq_im,
    output logic          ovf
);

    localparam int AW = DW + 1;       // xp+-xq
    localparam int PW = DW + TW + 1;  // product of a DW+1-bit operand and the twiddle
    localparam int CW = DW + TW + 2;  // sum/difference of two products
    localparam int YW = DW + 2;       // requantised result
    localparam int SW = DW + 3;       // headroom for the scaling increment

    localparam logic [CW-1:0]        RND_HALF = CW'(1) << (TW - 2);
    localparam logic signed [SW-1:0] SAT_MAX  = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN  = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic signed [PW-1:0] ext_a(input logic [AW-1:0] v);
        return {{(PW-AW){v[AW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] ext_t(input logic [TW-1:0] v);
        return {{(PW-TW){v[TW-1]}}, v};
    endfunction

    // Full-precision combine of two products, then round half up back to Q0 with DW+2 bits kept.
    function automatic logic [YW-1:0] combine_round(input logic signed [PW-1:0] pa,
                                                    input logic signed [PW-1:0] pb,
                                                    input logic             sub);
        logic signed [CW-1:0] a_w;
        logic signed [CW-1:0] b_w;
        logic signed [CW-1:0] s;
        a_w = {{(CW-PW){pa[PW-1]}}, pa};
        b_w = {{(CW-PW){pb[PW-1]}}, pb};
        s   = sub ? (a_w - b_w) : (a_w + b_w);
        s   = s + $signed(RND_HALF);
        s   = s >>> (TW - 1);
        return s[YW-1:0];
    endfunction

    // ---------------- stage registers ----------------
    logic                 s1_vld_q, s1_mode_q, s1_scale_q;
    logic [AW-1:0]        s1_hold_re_q, s1_hold_im_q, s1_hold_re_d, s1_hold_im_d;
    logic [AW-1:0]        s1_diff_re_q, s1_diff_im_q, s1_diff_re_d, s1_diff_im_d;
    logic [TW-1:0]        s1_w_re_q, s1_w_im_q;
    logic signed [PW-1:0] s1_p_q [4];
    logic signed [PW-1:0] s1_p_d [4];

    logic                 s2_vld_q, s2_mode_q, s2_scale_q;
    logic [AW-1:0]        s2_hold_re_q, s2_hold_im_q;
    logic [YW-1:0]        s2_t_re_q, s2_t_im_q, s2_t_re_d, s2_t_im_d;
    logic signed [PW-1:0] s2_p_q [4];
    logic signed [PW-1:0] s2_p_d [4];

    logic                 s3_vld_q, s3_scale_q;
    logic [YW-1:0]        s3_y_q [4];
    logic [YW-1:0]        s3_y_d [4];

    logic                 out_vld_q;
    logic [DW-1:0]        y_q [4];
    logic                 ovf_q, ovf_d;

    logic [3:0]           lane_sat;
    logic [DW-1:0]        lane_y [4];

    // ---------------- S1: DIT products / DIF sum and difference ----------------
    logic [AW-1:0] xp_re_a, xp_im_a, xq_re_a, xq_im_a;

    always_comb begin
        xp_re_a = {xp_re[DW-1], xp_re};
        xp_im_a = {xp_im[DW-1], xp_im};
        xq_re_a = {xq_re[DW-1], xq_re};
        xq_im_a = {xq_im[DW-1], xq_im};

        s1_hold_re_d = mode ? (xp_re_a + xq_re_a) : xp_re_a;
        s1_hold_im_d = mode ? (xp_im_a + xq_im_a) : xp_im_a;
        s1_diff_re_d = xp_re_a - xq_re_a;
        s1_diff_im_d = xp_im_a - xq_im_a;

        s1_p_d[0] = ext_a(xq_re_a) * ext_t(factor_re);
        s1_p_d[1] = ext_a(xq_im_a) * ext_t(factor_im);
        s1_p_d[2] = ext_a(xq_re_a) * ext_t(factor_im);
        s1_p_d[3] = ext_a(xq_im_a) * ext_t(factor_re);
    end

    // ---------------- S2: DIT combine+round / DIF products ----------------
    always_comb begin
        s2_t_re_d = combine_round(s1_p_q[0], s1_p_q[1], 1'b1);
        s2_t_im_d = combine_round(s1_p_q[2], s1_p_q[3], 1'b0);

        s2_p_d[0] = ext_a(s1_diff_re_q) * ext_t(s1_w_re_q);
        s2_p_d[1] = ext_a(s1_diff_im_q) * ext_t(s1_w_im_q);
        s2_p_d[2] = ext_a(s1_diff_re_q) * ext_t(s1_w_im_q);
        s2_p_d[3] = ext_a(s1_diff_im_q) * ext_t(s1_w_re_q);
    end

    // ---------------- S3: DIT add/sub / DIF combine+round ----------------
    logic [YW-1:0] hold_re_y, hold_im_y;

    always_comb begin
        hold_re_y = {s2_hold_re_q[AW-1], s2_hold_re_q};
        hold_im_y = {s2_hold_im_q[AW-1], s2_hold_im_q};
        if (s2_mode_q) begin
            s3_y_d[0] = hold_re_y;
            s3_y_d[1] = hold_im_y;
            s3_y_d[2] = combine_round(s2_p_q[0], s2_p_q[1], 1'b1);
            s3_y_d[3] = combine_round(s2_p_q[2], s2_p_q[3], 1'b0);
        end else begin
            s3_y_d[0] = hold_re_y + s2_t_re_q;
            s3_y_d[1] = hold_im_y + s2_t_im_q;
            s3_y_d[2] = hold_re_y - s2_t_re_q;
            s3_y_d[3] = hold_im_y - s2_t_im_q;
        end
    end

    // ---------------- S4: per-component scaling and saturation ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [SW-1:0] v_ext;
            logic signed [SW-1:0] v_inc;
            logic signed [SW-1:0] v_scl;
            logic                 hi, lo;
            always_comb begin
                v_ext = {s3_y_q[gi][YW-1], s3_y_q[gi]};
                v_inc = v_ext + SW'(1);
                v_scl = s3_scale_q ? (v_inc >>> 1) : v_ext;
                hi    = (v_scl > SAT_MAX);
                lo    = (v_scl < SAT_MIN);
            end
            assign lane_sat[gi] = hi | lo;
            assign lane_y[gi]   = hi ? SAT_MAX[DW-1:0] : (lo ? SAT_MIN[DW-1:0] : v_scl[DW-1:0]);
        end
    endgenerate

    // A new saturation event takes priority over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (s3_vld_q && (|lane_sat)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_scale_q   <= 1'b0;
            s1_hold_re_q <= '0;
            s1_hold_im_q <= '0;
            s1_diff_re_q <= '0;
            s1_diff_im_q <= '0;
            s1_w_re_q    <= '0;
            s1_w_im_q    <= '0;
            s2_vld_q     <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_scale_q   <= 1'b0;
            s2_hold_re_q <= '0;
            s2_hold_im_q <= '0;
            s2_t_re_q    <= '0;
            s2_t_im_q    <= '0;
            s3_vld_q     <= 1'b0;
            s3_scale_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s1_p_q[i] <= '0;
                s2_p_q[i] <= '0;
                s3_y_q[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            s1_vld_q  <= in_vld;
            s2_vld_q  <= s1_vld_q;
            s3_vld_q  <= s2_vld_q;
            out_vld_q <= s3_vld_q;
            ovf_q     <= ovf_d;

            if (in_vld) begin
                s1_mode_q    <= mode;
                s1_scale_q   <= scale;
                s1_hold_re_q <= s1_hold_re_d;
                s1_hold_im_q <= s1_hold_im_d;
                s1_diff_re_q <= s1_diff_re_d;
                s1_diff_im_q <= s1_diff_im_d;
                s1_w_re_q    <= factor_re;
                s1_w_im_q    <= factor_im;
                for (int i = 0; i < 4; i++) s1_p_q[i] <= s1_p_d[i];
            end

            if (s1_vld_q) begin
                s2_mode_q    <= s1_mode_q;
                s2_scale_q   <= s1_scale_q;
                s2_hold_re_q <= s1_hold_re_q;
                s2_hold_im_q <= s1_hold_im_q;
                s2_t_re_q    <= s2_t_re_d;
                s2_t_im_q    <= s2_t_im_d;
                for (int i = 0; i < 4; i++) s2_p_q[i] <= s2_p_d[i];
            end

            if (s2_vld_q) begin
                s3_scale_q <= s2_scale_q;
                for (int i = 0; i < 4; i++) s3_y_q[i] <= s3_y_d[i];
            end

            if (s3_vld_q) begin
                for (int i = 0; i < 4; i++) y_q[i] <= lane_y[i];
            end
        end
    end

    assign out_vld = out_vld_q;
    assign yp_re   = y_q[0];
    assign yp_im   = y_q[1];
    assign yq_re   = y_q[2];
    assign yq_im   = y_q[3];
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Directed bench for butterfly_r2_pipe: hand-computed vectors covering DIT/DIF, scaling,
// saturation/ovf, back-to-back throughput with gaps, and asynchronous reset mid-stream.
module tb_butterfly_r2_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld, mode, scale, ovf_clr;
    logic [DW-1:0] xp_re, xp_im, xq_re, xq_im;
    logic [TW-1:0] factor_re, factor_im;
    logic          out_vld, ovf;
    logic [DW-1:0] yp_re, yp_im, yq_re, yq_im;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    butterfly_r2_pipe #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .mode      (mode),
        .scale     (scale),
        .xp_re     (xp_re),
        .xp_im     (xp_im),
        .xq_re     (xq_re),
        .xq_im     (xq_im),
        .factor_re (factor_re),
        .factor_im (factor_im),
        .ovf_clr   (ovf_clr),
        .out_vld   (out_vld),
        .yp_re     (yp_re),
        .yp_im     (yp_im),
        .yq_re     (yq_re),
        .yq_im     (yq_im),
        .ovf       (ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_y(input string tag, input int epr, input int epi, input int eqr, input int eqi);
        $display("%0t %s: yp=(%0d,%0d) yq=(%0d,%0d) vld=%0d ovf=%0d", $time, tag,
                 $signed(yp_re), $signed(yp_im), $signed(yq_re), $signed(yq_im), out_vld, ovf);
        chk({tag, ".yp_re"}, $signed(yp_re), epr);
        chk({tag, ".yp_im"}, $signed(yp_im), epi);
        chk({tag, ".yq_re"}, $signed(yq_re), eqr);
        chk({tag, ".yq_im"}, $signed(yq_im), eqi);
    endtask

    task automatic drive(input logic m, input logic s, input int xpr, input int xpi,
                         input int xqr, input int xqi, input int wr, input int wi);
        in_vld    = 1'b1;
        mode      = m;
        scale     = s;
        xp_re     = DW'(xpr);
        xp_im     = DW'(xpi);
        xq_re     = DW'(xqr);
        xq_im     = DW'(xqi);
        factor_re = TW'(wr);
        factor_im = TW'(wi);
    endtask

    task automatic idle();
        in_vld = 1'b0;
        mode   = 1'b0;
        scale  = 1'b0;
    endtask

    // Throughput vectors: mode alternates, scale toggles every two samples.
    int t_m   [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int t_s   [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int t_xpr [8] = '{100, 100, -500, -500, 7, 7, 3, 1};
    int t_xpi [8] = '{200, 200, 300, 300, -9, -9, -3, 1};
    int t_xqr [8] = '{10, 10, -100, -100, 3, 3, 0, 0};
    int t_xqi [8] = '{20, 20, 50, 50, 5, 5, 0, 0};
    int t_wr  [8] = '{0, 0, -32768, -32768, 32767, 32767, 0, 0};
    int t_wi  [8] = '{-32768, -32768, 0, 0, 0, 0, -32768, -32768};
    int e_pr  [8] = '{120, 110, -200, -300, 10, 10, 2, 1};
    int e_pi  [8] = '{190, 220, 125, 175, -4, -4, -1, 1};
    int e_qr  [8] = '{80, 180, -300, 200, 4, 4, 2, 1};
    int e_qi  [8] = '{210, -90, 175, -125, -14, -14, -1, 0};

    initial begin
        rst_n = 1'b1;
        ovf_clr = 1'b0;
        idle();
        xp_re = '0; xp_im = '0; xq_re = '0; xq_im = '0;
        factor_re = '0; factor_im = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset.out_vld", 32'(out_vld), 0);
        chk("reset.ovf", 32'(ovf), 0);
        chk_y("reset", 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // DIT, no scaling, W = -j
        drive(0, 0, 1000, 2000, 300, 400, 0, -32768);
        step();
        idle();
        step();
        step();
        chk("dit.early_vld", 32'(out_vld), 0);
        step();
        chk("dit.out_vld", 32'(out_vld), 1);
        chk("dit.ovf", 32'(ovf), 0);
        chk_y("dit", 1400, 1700, 600, 2300);
        step();
        chk("dit.vld_one_cycle", 32'(out_vld), 0);
        chk("dit.hold_yp_re", $signed(yp_re), 1400);

        // DIT with scaling
        drive(0, 1, 1000, 2000, 300, 400, 0, -32768);
        step();
        idle();
        step(); step(); step();
        chk("dit_scl.out_vld", 32'(out_vld), 1);
        chk_y("dit_scl", 700, 850, 300, 1150);

        // Saturation on yp_re, then sticky ovf and clear
        drive(0, 0, 32767, 0, 32767, 0, 32767, 0);
        step();
        idle();
        step(); step(); step();
        chk_y("sat1", 32767, 0, 1, 0);
        chk("sat1.ovf", 32'(ovf), 1);
        step(); step(); step();
        chk("sat1.ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sat1.ovf_cleared", 32'(ovf), 0);

        // Most-negative product, saturation coinciding with a clear request
        drive(0, 0, 0, 0, -32768, 0, -32768, 0);
        step();
        idle();
        step(); step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk_y("sat2", 32767, 0, -32768, 0);
        chk("sat2.ovf_set_wins", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sat2.ovf_cleared", 32'(ovf), 0);

        // DIF
        drive(1, 0, 1000, 0, 200, 0, 0, -32768);
        step();
        idle();
        step(); step(); step();
        chk("dif.out_vld", 32'(out_vld), 1);
        chk_y("dif", 1200, 0, 0, -800);
        chk("dif.ovf", 32'(ovf), 0);
        step(); step();

        // Back-to-back: 8 samples, mixed mode and scale
        for (int c = 0; c < 13; c++) begin
            if (c >= 4 && c < 12) begin
                chk($sformatf("tp%0d.out_vld", c - 4), 32'(out_vld), 1);
                chk_y($sformatf("tp%0d", c - 4), e_pr[c-4], e_pi[c-4], e_qr[c-4], e_qi[c-4]);
            end else begin
                chk($sformatf("tp.idle_vld_c%0d", c), 32'(out_vld), 0);
            end
            if (c < 8) begin
                drive(t_m[c][0], t_s[c][0], t_xpr[c], t_xpi[c], t_xqr[c], t_xqi[c], t_wr[c], t_wi[c]);
            end else begin
                idle();
            end
            step();
        end

        // Two-cycle gap in in_vld reappears at the output
        for (int c = 0; c < 9; c++) begin
            if (c == 4) begin
                chk("gap.vld_a", 32'(out_vld), 1);
                chk_y("gap.a", e_pr[0], e_pi[0], e_qr[0], e_qi[0]);
            end else if (c == 5 || c == 6) begin
                chk($sformatf("gap.vld_c%0d", c), 32'(out_vld), 0);
                chk($sformatf("gap.hold_c%0d", c), $signed(yp_re), e_pr[0]);
            end else if (c == 7) begin
                chk("gap.vld_b", 32'(out_vld), 1);
                chk_y("gap.b", e_pr[4], e_pi[4], e_qr[4], e_qi[4]);
            end else if (c == 8) begin
                chk("gap.vld_end", 32'(out_vld), 0);
            end
            if (c == 0) begin
                drive(t_m[0][0], t_s[0][0], t_xpr[0], t_xpi[0], t_xqr[0], t_xqi[0], t_wr[0], t_wi[0]);
            end else if (c == 3) begin
                drive(t_m[4][0], t_s[4][0], t_xpr[4], t_xpi[4], t_xqr[4], t_xqi[4], t_wr[4], t_wi[4]);
            end else begin
                idle();
            end
            step();
        end

        // Reset with 3 samples in flight, after a saturating result set ovf
        drive(0, 0, 32767, 0, 32767, 0, 32767, 0);
        step();
        idle();
        step(); step(); step();
        chk("rst.pre_ovf", 32'(ovf), 1);
        chk("rst.pre_yp_re", $signed(yp_re), 32767);
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 1000 + c, 2000, 300, 400, 0, -32768);
            step();
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_vld", 32'(out_vld), 0);
        chk("rst.ovf", 32'(ovf), 0);
        chk_y("rst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("rst.post_vld_c%0d", c), 32'(out_vld), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
- Parametrised radix-2 complex butterfly for the FFT datapath. It is the next generation of the fixed 16-bit butterfly.
- Supports both DIT and DIF modes, selectable per sample.
- Optional per-sample divide-by-2 scaling, round-half-up on every requantisation, and output saturation with a sticky overflow flag.
- Fully pipelined: accepts one butterfly per cycle, fixed latency 4, and sits between the stage RAMs and the twiddle ROM.

Parameters:
DW, 16, data width of xp/xq/yp/yq real and imaginary parts (two's complement)
TW, 16, twiddle width, format Q1.(TW-1); -1.0 is exact, +1.0 is represented as 2^(TW-1)-1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  input sample valid
mode  in  1  0 = DIT (yp=xp+xq*W, yq=xp-xq*W), 1 = DIF (yp=xp+xq, yq=(xp-xq)*W)
scale  in  1  1 = divide both outputs by 2 with rounding
xp_re  in  DW  upper input, real
xp_im  in  DW  upper input, imag
xq_re  in  DW  lower input, real
xq_im  in  DW  lower input, imag
factor_re  in  TW  twiddle, real
factor_im  in  TW  twiddle, imag
ovf_clr  in  1  synchronous clear of ovf
out_vld  out  1  output valid
yp_re  out  DW  upper output, real
yp_im  out  DW  upper output, imag
yq_re  out  DW  lower output, real
yq_im  out  DW  lower output, imag
ovf  out  1  sticky, set when any output component saturated

Behaviour:
- Reset (asynchronous, rst_n low):
  - All pipeline registers clear immediately, including out_vld, all y outputs and ovf.
  - In-flight samples are discarded. No output is produced for them after release.
- Pipeline: 4 register stages with no stall.
  - in_vld, mode and scale travel with the data.
  - out_vld at cycle N+4 equals in_vld at cycle N.
  - Stage registers load only when their stage-valid bit is 1. Otherwise they hold.
  - Outputs hold their last value while out_vld=0.
- DIT stages:
  - S1: four products xq_re*f_re, xq_im*f_im, xq_re*f_im, xq_im*f_re, each DW+TW bits.
  - S2: re = p0-p1, im = p2+p3 at DW+TW+1 bits. Round by adding 2^(TW-2), then arithmetic shift right by TW-1. Keep DW+2 bits.
  - S3: sum = xp+t and diff = xp-t at DW+2 bits. xp is delayed alongside.
- DIF stages:
  - S1: a = xp+xq and d = xp-xq at DW+1 bits.
  - S2: four products of d with W.
  - S3: combine and round as in DIT S2, giving yq. a is delayed to align.
- S4, common to both modes:
  - If scale=1, each component becomes (v+1)>>>1 (arithmetic shift).
  - Each component then saturates to [-2^(DW-1), 2^(DW-1)-1].
- Products: no truncation before combine. (-2^(DW-1))*(-2^(TW-1)) must not wrap.
- ovf:
  - Set the cycle after any S4 component with valid=1 saturates.
  - Cleared by ovf_clr.
  - A set in the same cycle as ovf_clr wins.
- mode and scale may change every cycle. Alternating samples must not corrupt each other.

Test Plan:
1. DIT, DW=TW=16, scale=0: xp=(1000,2000), xq=(300,400), W=(0,-32768) → 4 cycles later yp=(1400,1700), yq=(600,2300), out_vld=1 for one cycle, ovf=0.
2. Same inputs with scale=1 → yp=(700,850), yq=(300,1150).
3. Saturation, DIT: xp=(32767,0), xq=(32767,0), W=(32767,0) → product re=32766, yp_re=32767 saturated, yq_re=1, ovf=1. ovf stays 1 until ovf_clr pulse, then 0. Second case: xp=0, xq=(-32768,0), W=(-32768,0) → yp_re=32767 (saturated), yq_re=-32768, ovf=1.
4. DIF: xp=(1000,0), xq=(200,0), W=(0,-32768), mode=1 → yp=(1200,0), yq=(0,-800).
5. Throughput: 8 back-to-back samples with in_vld=1, mode alternating 0/1 and scale alternating → 8 consecutive out_vld cycles starting 4 cycles after the first input, each result matching the golden model in order. An in_vld gap of 2 cycles appears as an identical 2-cycle out_vld gap.
6. Reset mid-stream: assert rst_n low while 3 samples are in flight → out_vld, outputs and ovf go to 0 immediately. After release with in_vld=0, out_vld stays 0 for 6 cycles.
